// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW dictionary lookup controller: default widths,
// FSM state encoding and the reserved empty-slot key.
package lzw_pkg;
    localparam int LZW_DATA_WIDTH = 64;
    localparam int LZW_HASH_WIDTH = 12;
    localparam logic [LZW_DATA_WIDTH-1:0] EMPTY_KEY = '0;

    typedef enum logic [2:0] {
        IDLE,
        RAM_RD,
        RAM_CMP,
        CT_RD,
        CT_WAIT,
        WR_RAM,
        WR_CT,
        RESP
    } state_e;
endpackage

// File: rtl/lzw_dict_ctrl_if.sv
// Lookup request / response handshake between a requester (master) and the
// dictionary controller (slave).
interface lzw_dict_ctrl_if #(
    parameter int DW = lzw_pkg::LZW_DATA_WIDTH,
    parameter int HW = lzw_pkg::LZW_HASH_WIDTH
);
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_key;
    logic [HW-1:0] req_hash;
    logic [HW-1:0] req_code;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_hit;
    logic [HW-1:0] rsp_code;
    logic          rsp_full;

    modport master (
        output req_valid, req_key, req_hash, req_code, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_code, rsp_full
    );
    modport slave (
        input  req_valid, req_key, req_hash, req_code, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_code, rsp_full
    );
endinterface

// File: rtl/lzw_dict_ctrl.sv
// LZW dictionary controller: looks a key up in a direct-mapped hash RAM, falls
// back to an external conflict table on collision, and inserts on a miss.
module lzw_dict_ctrl #(
    parameter int DATA_WIDTH = lzw_pkg::LZW_DATA_WIDTH,
    parameter int HASH_WIDTH = lzw_pkg::LZW_HASH_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    lzw_dict_ctrl_if.slave        bus,
    output logic [HASH_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wkey,
    output logic [HASH_WIDTH-1:0] ram_wcode,
    input  logic [DATA_WIDTH-1:0] ram_rkey,
    input  logic [HASH_WIDTH-1:0] ram_rcode,
    output logic                  ct_cs,
    output logic                  ct_we,
    output logic [DATA_WIDTH-1:0] ct_data,
    output logic [HASH_WIDTH-1:0] ct_hash,
    output logic [HASH_WIDTH-1:0] ct_map,
    input  logic                  ct_match,
    input  logic [HASH_WIDTH-1:0] ct_map_out,
    input  logic                  ct_full
);
    import lzw_pkg::*;

    localparam logic [DATA_WIDTH-1:0] EMPTY = DATA_WIDTH'(EMPTY_KEY);

    state_e                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] key_q, key_d;
    logic [HASH_WIDTH-1:0] hash_q, hash_d;
    logic [HASH_WIDTH-1:0] code_q, code_d;
    logic                  hit_q, hit_d;
    logic                  full_q, full_d;
    logic [HASH_WIDTH-1:0] rcode_q, rcode_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            key_q   <= '0;
            hash_q  <= '0;
            code_q  <= '0;
            hit_q   <= 1'b0;
            full_q  <= 1'b0;
            rcode_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            key_q   <= key_d;
            hash_q  <= hash_d;
            code_q  <= code_d;
            hit_q   <= hit_d;
            full_q  <= full_d;
            rcode_q <= rcode_d;
        end
    end

    // Ready is registered so it stays low throughout reset and rises on the
    // first edge after release.
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_hit   = hit_q;
    assign bus.rsp_full  = full_q;
    assign bus.rsp_code  = rcode_q;

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        hash_d    = hash_q;
        code_d    = code_q;
        hit_d     = hit_q;
        full_d    = full_q;
        rcode_d   = rcode_q;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wkey  = '0;
        ram_wcode = '0;
        ct_cs     = 1'b0;
        ct_we     = 1'b0;
        ct_data   = '0;
        ct_hash   = '0;
        ct_map    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    key_d  = bus.req_key;
                    hash_d = bus.req_hash;
                    code_d = bus.req_code;
                    hit_d  = 1'b0;
                    full_d = 1'b0;
                    // The reserved empty key never touches either table.
                    if (bus.req_key == EMPTY) begin
                        rcode_d = '0;
                        state_d = RESP;
                    end else begin
                        rcode_d  = bus.req_code;
                        ram_addr = bus.req_hash;
                        state_d  = RAM_RD;
                    end
                end
            end
            RAM_RD: begin
                ram_addr = hash_q;
                state_d  = RAM_CMP;
            end
            RAM_CMP: begin
                if (ram_rkey == EMPTY) begin
                    state_d = WR_RAM;
                end else if (ram_rkey == key_q) begin
                    hit_d   = 1'b1;
                    rcode_d = ram_rcode;
                    state_d = RESP;
                end else begin
                    state_d = CT_RD;
                end
            end
            CT_RD: begin
                ct_cs   = 1'b1;
                ct_data = key_q;
                if (ct_match) begin
                    state_d = CT_WAIT;
                end else if (ct_full) begin
                    full_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WR_CT;
                end
            end
            CT_WAIT: begin
                ct_cs   = 1'b1;
                ct_data = key_q;
                hit_d   = 1'b1;
                rcode_d = ct_map_out;
                state_d = RESP;
            end
            WR_RAM: begin
                ram_we    = 1'b1;
                ram_addr  = hash_q;
                ram_wkey  = key_q;
                ram_wcode = code_q;
                state_d   = RESP;
            end
            WR_CT: begin
                ct_cs   = 1'b1;
                ct_we   = 1'b1;
                ct_data = key_q;
                ct_hash = hash_q;
                ct_map  = code_q;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end
endmodule
